// File: rtl/cv_bus_pkg.sv
// cv_bus_pkg: shared types and constants for the Colecovision bus-cycle initiator
package cv_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_RF1, S_RF2
    } state_e;

    typedef enum logic [2:0] {
        MEM_RD, MEM_WR, IO_RD, IO_WR, REFRESH
    } cycle_e;

    typedef struct packed {
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } strobes_t;

    localparam int unsigned IO_AUTO_WAITS = 1;
    localparam strobes_t    STROBES_IDLE  = '1;

    function automatic cycle_e cycle_of(input logic we, input logic io);
        return io ? (we ? IO_WR : IO_RD) : (we ? MEM_WR : MEM_RD);
    endfunction

endpackage

// File: rtl/cv_refresh_timer.sv
// cv_refresh_timer: counts enabled T-states and raises a single pending-refresh flag at each wrap
module cv_refresh_timer #(
    parameter int unsigned INTERVAL = 128
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic pending_o
);

    localparam int unsigned     CW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0]   LAST = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d, wrap;

    // wrap detection; a wrap on the same edge as a clear keeps the flag set so no refresh is lost
    always_comb begin
        wrap      = en_i && (INTERVAL != 0) && (cnt_q == LAST);
        cnt_d     = !en_i ? cnt_q : (wrap ? '0 : cnt_q + 1'b1);
        pending_d = wrap || (pending_q && !clr_i);
    end

    // counter and pending flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cv_bus_master.sv
// cv_bus_master: Z80-style memory/I-O/refresh bus cycles driven from a req/ack handshake
module cv_bus_master
    import cv_bus_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 128
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clk_en_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic        io_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        ack_o,
    output logic [7:0]  rd_data_o,
    output logic        busy_o,
    output logic [15:0] a_o,
    output logic [7:0]  d_o,
    output logic        d_oe_o,
    input  logic [7:0]  d_i,
    output logic        mreq_n_o,
    output logic        iorq_n_o,
    output logic        rd_n_o,
    output logic        wr_n_o,
    output logic        rfsh_n_o,
    input  logic        wait_n_i
);

    state_e      state_q, state_d;
    cycle_e      cycle_q, cycle_d;
    strobes_t    stb_q, stb_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  d_q, d_d, rd_data_q, rd_data_d;
    logic [6:0]  r_q, r_d;
    logic        d_oe_q, d_oe_d, busy_q, busy_d, ack_q, ack_d;
    logic        pending, rfsh_clr;
    logic        mem_d, io_d, rd_d, wr_d, bus_all, bus_late;

    cv_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (clk_en_i),
        .clr_i     (rfsh_clr),
        .pending_o (pending)
    );

    // state, cycle type and bus address/data registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cycle_q   <= MEM_RD;
            stb_q     <= STROBES_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            d_oe_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
            r_q       <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            stb_q     <= stb_d;
            a_q       <= a_d;
            d_q       <= d_d;
            d_oe_q    <= d_oe_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
            r_q       <= r_d;
        end
    end

    // next state; refresh beats a request in IDLE, and the request is latched on leaving IDLE
    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        a_d      = a_q;
        d_d      = d_q;
        rfsh_clr = 1'b0;
        if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (pending) begin
                        state_d  = S_RF1;
                        cycle_d  = REFRESH;
                        a_d      = {9'h000, r_q};
                        rfsh_clr = 1'b1;
                    end else if (req_i) begin
                        state_d = S_T1;
                        cycle_d = cycle_of(we_i, io_i);
                        a_d     = addr_i;
                        d_d     = wdata_i;
                    end
                end
                S_T1:        state_d = S_T2;
                S_T2:        state_d = ((cycle_q inside {IO_RD, IO_WR}) && IO_AUTO_WAITS != 0) ? S_TWA :
                                       (wait_n_i ? S_T3 : S_TW);
                S_TWA, S_TW: state_d = wait_n_i ? S_T3 : S_TW;
                S_RF1:       state_d = S_RF2;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // registered outputs decoded from the state being entered so strobes line up with the T-state
    always_comb begin
        mem_d       = cycle_d inside {MEM_RD, MEM_WR};
        io_d        = cycle_d inside {IO_RD, IO_WR};
        rd_d        = cycle_d inside {MEM_RD, IO_RD};
        wr_d        = cycle_d inside {MEM_WR, IO_WR};
        bus_late    = state_d inside {S_T2, S_TWA, S_TW, S_T3};
        bus_all     = bus_late || state_d == S_T1;
        stb_d       = STROBES_IDLE;
        stb_d.mreq_n = !((mem_d && bus_all) || state_d == S_RF2);
        stb_d.iorq_n = !(io_d && bus_late);
        stb_d.rd_n   = !(rd_d && (mem_d ? bus_all : bus_late));
        stb_d.wr_n   = !(wr_d && bus_late);
        stb_d.rfsh_n = !(state_d inside {S_RF1, S_RF2});
        d_oe_d      = wr_d && bus_all;
        busy_d      = state_d != S_IDLE;
        ack_d       = clk_en_i && state_q == S_T3;
        rd_data_d   = (ack_d && (cycle_q inside {MEM_RD, IO_RD})) ? d_i : rd_data_q;
        r_d         = (clk_en_i && state_q == S_RF2) ? r_q + 7'd1 : r_q;
    end

    assign ack_o     = ack_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign a_o       = a_q;
    assign d_o       = d_q;
    assign d_oe_o    = d_oe_q;
    assign mreq_n_o  = stb_q.mreq_n;
    assign iorq_n_o  = stb_q.iorq_n;
    assign rd_n_o    = stb_q.rd_n;
    assign wr_n_o    = stb_q.wr_n;
    assign rfsh_n_o  = stb_q.rfsh_n;

endmodule

// File: tb/tb_cv_bus_master.sv
// tb_cv_bus_master: directed and randomized checks of cv_bus_master against a T-state waveform model
module tb_cv_bus_master;

    localparam int INTV = 4;

    logic        clk_i = 1'b0;
    logic        reset_n_i, clk_en_i, req_i, we_i, io_i, wait_n_i;
    logic [15:0] addr_i, a_o;
    logic [7:0]  wdata_i, d_i, rd_data_o, d_o;
    logic        ack_o, busy_o, d_oe_o, mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o;

    always #5 clk_i = ~clk_i;

    cv_bus_master #(.REFRESH_INTERVAL(INTV)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_i(clk_en_i), .req_i(req_i),
        .we_i(we_i), .io_i(io_i), .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o),
        .rd_data_o(rd_data_o), .busy_o(busy_o), .a_o(a_o), .d_o(d_o), .d_oe_o(d_oe_o),
        .d_i(d_i), .mreq_n_o(mreq_n_o), .iorq_n_o(iorq_n_o), .rd_n_o(rd_n_o),
        .wr_n_o(wr_n_o), .rfsh_n_o(rfsh_n_o), .wait_n_i(wait_n_i)
    );

    // one expected T-state: strobes {mreq,iorq,rd,wr,rfsh}, bus values, and the wait_n to drive if sampled
    typedef struct packed {
        logic [4:0]  stb;
        logic [15:0] a;
        logic        doe;
        logic [7:0]  d;
        logic        samp;
        logic        wn;
    } ts_t;

    ts_t         plan[$];
    int          tcnt, checks, errors, req_k, mode, phase;
    bit          pend, cur_txn, cur_rd, wrap_now, scramble, d_fix_en;
    logic [6:0]  mr, last_rf;
    logic [15:0] ma;
    logic [7:0]  mrd, d_fix;
    int          nen, lat, last_lat, cnt_rdm, cnt_iowr, cnt_mwr, cnt_doe, cnt_rf, cnt_rf2, cnt_ack, cnt_busy;
    bit          lat_on, got, saw7f, saw_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        plan.delete();
        tcnt = 0; pend = 0; mr = '0; ma = '0; mrd = '0; cur_txn = 0;
        last_rf = 7'h7F; saw7f = 0;
    endtask

    task automatic add_txn(input logic we, input logic io, input logic [15:0] a, input logic [7:0] wd, input int k);
        ts_t  t;
        logic [4:0] on;
        int   n, base;
        on = io ? (we ? 5'b10101 : 5'b10011) : (we ? 5'b01101 : 5'b01011);
        t.stb = io ? 5'b11111 : (we ? 5'b01111 : 5'b01011);
        t.a = a; t.doe = we; t.d = wd; t.samp = 0; t.wn = 1;
        plan.push_back(t);
        t.stb = on; t.samp = !io; t.wn = (k == 0);
        plan.push_back(t);
        n = io ? k + 1 : k;
        base = io ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            t.samp = 1; t.wn = (base + i >= k);
            plan.push_back(t);
        end
        t.samp = 0; t.wn = 1;
        plan.push_back(t);
    endtask

    task automatic add_refresh();
        ts_t t;
        t.stb = 5'b11110; t.a = {9'h000, mr}; t.doe = 0; t.d = '0; t.samp = 0; t.wn = 1;
        plan.push_back(t);
        t.stb = 5'b01110;
        plan.push_back(t);
        mr = mr + 7'd1;
    endtask

    function automatic bit next_en();
        phase++;
        return (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : (phase % 3 == 0);
    endfunction

    task automatic cyc(input bit en);
        bit wrap, oldp, eack;
        clk_en_i = en;
        d_i = d_fix_en ? d_fix : 8'($urandom);
        wait_n_i = (plan.size() > 0 && plan[0].samp) ? plan[0].wn : 1'($urandom);
        @(posedge clk_i);
        eack = 0; wrap_now = 0;
        if (en && reset_n_i) begin
            wrap = (tcnt == INTV - 1);
            oldp = pend;
            tcnt = wrap ? 0 : tcnt + 1;
            if (plan.size() > 0) begin
                void'(plan.pop_front());
                if (plan.size() == 0 && cur_txn) begin
                    eack = 1;
                    if (cur_rd) mrd = d_i;
                end
            end else if (oldp) begin
                add_refresh(); pend = 0; cur_txn = 0;
            end else if (req_i) begin
                add_txn(we_i, io_i, addr_i, wdata_i, req_k); cur_txn = 1; cur_rd = !we_i;
            end
            if (wrap) begin pend = 1; wrap_now = 1; end
            if (plan.size() > 0) ma = plan[0].a;
        end
        #1;
        chk("strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o}, plan.size() > 0 ? plan[0].stb : 5'h1F);
        chk("a_o", a_o, ma);
        chk("busy_o", busy_o, plan.size() > 0);
        chk("d_oe_o", d_oe_o, plan.size() > 0 ? plan[0].doe : 1'b0);
        if (plan.size() > 0 && plan[0].doe) chk("d_o", d_o, plan[0].d);
        chk("ack_o", ack_o, eack);
        chk("rd_data_o", rd_data_o, mrd);
        if (en && reset_n_i) begin
            nen++;
            if (lat_on) lat++;
            else if (busy_o && rfsh_n_o) begin lat_on = 1; lat = 0; end
            if (!mreq_n_o && !rd_n_o) cnt_rdm++;
            if (!iorq_n_o && !wr_n_o) cnt_iowr++;
            if (!mreq_n_o && !wr_n_o) cnt_mwr++;
            if (d_oe_o) cnt_doe++;
            if (!rfsh_n_o) begin
                cnt_rf++;
                if (!mreq_n_o) cnt_rf2++;
                else begin
                    chk("rf_addr_seq", a_o, {9'h000, last_rf + 7'd1});
                    if (saw7f && last_rf == 7'h7F && a_o == 16'h0000) saw_wrap = 1;
                    if (a_o[6:0] == 7'h7F) saw7f = 1;
                    last_rf = a_o[6:0];
                end
            end
        end
        if (ack_o) begin cnt_ack++; last_lat = lat; end
        if (busy_o && rfsh_n_o) cnt_busy++;
        if (scramble && cur_txn && plan.size() > 0) begin
            addr_i = 16'($urandom); wdata_i = 8'($urandom); we_i = 1'($urandom); io_i = 1'($urandom);
        end
    endtask

    task automatic do_txn(input logic we, input logic io, input logic [15:0] addr, input logic [7:0] wd, input int k);
        we_i = we; io_i = io; addr_i = addr; wdata_i = wd; req_k = k; req_i = 1;
        lat_on = 0; nen = 0; got = 0; lat = 0; last_lat = -1;
        cnt_rdm = 0; cnt_iowr = 0; cnt_mwr = 0; cnt_doe = 0; cnt_rf = 0; cnt_rf2 = 0; cnt_ack = 0; cnt_busy = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            cyc(next_en());
            if (ack_o) got = 1;
        end
        chk("ack_timeout", got, 1'b1);
        req_i = 0;
    endtask

    initial begin
        checks = 0; errors = 0; mode = 0; phase = 0; scramble = 0; d_fix_en = 0; d_fix = '0;
        reset_n_i = 0; clk_en_i = 1; req_i = 0; we_i = 0; io_i = 0; addr_i = '0; wdata_i = '0;
        d_i = '0; wait_n_i = 1; req_k = 0; saw_wrap = 0;
        reset_model();
        cyc(1); cyc(1);
        chk("rst_strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o}, 5'h1F);
        chk("rst_a_o", a_o, 16'h0000);
        chk("rst_d_o", d_o, 8'h00);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        #2 reset_n_i = 1;

        d_fix_en = 1; d_fix = 8'hA5;
        do_txn(0, 0, 16'h2000, 8'h00, 0);
        d_fix_en = 0;
        chk("mrd_data", rd_data_o, 8'hA5);
        chk("mrd_strobe_states", cnt_rdm, 3);
        chk("mrd_ack_count", cnt_ack, 1);
        chk("mrd_latency", last_lat, 3);

        do_txn(1, 1, 16'h007F, 8'h0F, 0);
        chk("iow_addr", a_o, 16'h007F);
        chk("iow_strobe_states", cnt_iowr, 3);
        chk("iow_doe_states", cnt_doe, 4);
        chk("iow_latency", last_lat, 4);
        chk("iow_rd_data_kept", rd_data_o, 8'hA5);

        do_txn(1, 0, 16'h3456, 8'h5A, 3);
        chk("mwr_strobe_states", cnt_mwr, 5);
        chk("mwr_latency", last_lat, 6);

        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1);
            if (wrap_now && plan.size() == 0) got = 1;
        end
        chk("pend_found", got, 1'b1);
        do_txn(0, 0, 16'h1234, 8'h00, 0);
        chk("rf_req_states", cnt_rf, 2);
        chk("rf_req_rf2_mreq", cnt_rf2, 1);
        chk("rf_req_total_edges", nen, 7);
        chk("rf_req_latency", last_lat, 3);

        mode = 2; phase = 0;
        do_txn(0, 0, 16'h4000, 8'h00, 0);
        chk("en3_strobe_states", cnt_rdm, 3);
        chk("en3_latency", last_lat, 3);
        chk("en3_ack_width", cnt_ack, 1);
        cyc(next_en());
        chk("en3_ack_clear", ack_o, 1'b0);
        mode = 0;

        we_i = 0; io_i = 1; addr_i = 16'h0042; req_k = 0; req_i = 1; got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            cyc(1);
            if (cur_txn && plan.size() == 3) got = 1;
        end
        chk("ior_reached_t2", got, 1'b1);
        #2 reset_n_i = 0;
        reset_model();
        #1;
        chk("mid_rst_strobes", {mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o}, 5'h1F);
        chk("mid_rst_ack", ack_o, 1'b0);
        chk("mid_rst_a_o", a_o, 16'h0000);
        chk("mid_rst_doe", d_oe_o, 1'b0);
        chk("mid_rst_rd_data", rd_data_o, 8'h00);
        cyc(1); cyc(1);
        #2 reset_n_i = 1;
        do_txn(0, 1, 16'h0042, 8'h00, 0);
        chk("ior_reissue_latency", last_lat, 4);

        req_i = 0;
        for (int i = 0; i < 600; i++) cyc(1);
        chk("r_wrap_seen", saw_wrap, 1'b1);

        mode = 1; scramble = 1;
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 3));
            for (int g = $urandom_range(0, 3); g > 0; g--) cyc(next_en());
        end
        scramble = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
